// File: rtl/rx_uart.sv
// rx_uart: 8N1 serial receiver. Two-flop synchronizer, mid-bit sampling FSM,
// one-entry output buffer drained by valid/ready, framing-error and overrun pulses.
module rx_uart #(
    parameter int unsigned SYSTEM_CLK = 100_000_000,
    parameter int unsigned BAUDRATE   = 9600
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CPS  = SYSTEM_CLK / BAUDRATE;
    localparam int unsigned HALF = CPS / 2;
    localparam int unsigned CW   = $clog2(CPS) + 1;

    localparam logic [CW-1:0] CntHalf = CW'(HALF - 1);
    localparam logic [CW-1:0] CntFull = CW'(CPS - 1);

    // Below four clocks per bit there is no usable mid-bit sample point.
    if (CPS < 4) begin : g_bad_cfg
        $error("rx_uart: SYSTEM_CLK/BAUDRATE must be at least 4");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rx_s_q;

    logic [7:0]    rx_data_q, rx_data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic          cnt_zero;
    logic          stop_sample;
    logic          accept;

    assign cnt_zero    = (cnt_q == '0);
    assign stop_sample = (state_q == StStop) && cnt_zero;
    assign accept      = valid_q && ready;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM state register together with the bit timer and shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: bit timing and deserialization.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    cnt_d   = CntHalf;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_zero) begin
                    if (!rx_s_q) begin
                        cnt_d     = CntFull;
                        bit_idx_d = '0;
                        state_d   = StData;
                    end else begin
                        // Start bit did not survive to mid-bit: treat as a glitch.
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StData: begin
                if (cnt_zero) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    cnt_d     = CntFull;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StStop: begin
                if (cnt_zero) begin
                    // Leaving at mid-stop-bit lets back-to-back frames be caught.
                    state_d = rx_s_q ? StIdle : StWaitHigh;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StWaitHigh: begin
                // Hold off until the line recovers so a break reports only once.
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic: buffer commit, handshake drain and status pulses.
    always_comb begin
        rx_data_d   = rx_data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        if (accept) begin
            valid_d = 1'b0;
        end
        if (stop_sample) begin
            if (rx_s_q) begin
                // A byte being accepted this cycle frees the slot for the new one.
                if (!valid_q || accept) begin
                    rx_data_d = shift_q;
                    valid_d   = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_data_q   <= rx_data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart: directed bench for rx_uart at 10 clocks per bit.
module tb_rx_uart;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx_in;
    logic       ready;
    logic [7:0] rx_data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned fe_cnt   = 0;
    int unsigned ov_cnt   = 0;
    int unsigned both_cnt = 0;
    int unsigned fe0;
    int unsigned ov0;
    logic [7:0]  acc_q[$];

    rx_uart #(
        .SYSTEM_CLK(1_000_000),
        .BAUDRATE  (100_000)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters and accepted-byte log, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (frame_err && overrun) both_cnt <= both_cnt + 1;
        if (valid && ready) acc_q.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives the first nbits of a frame (LSB first), 10 clocks each; call at a negedge.
    task automatic send_bits(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx_in = frame[i];
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits({stop, d, 1'b0}, 10);
    endtask

    initial begin
        resetn = 1'b0;
        rx_in  = 1'b1;
        ready  = 1'b0;
        repeat (5) @(negedge clk);
        check("reset", 32'({valid, frame_err, overrun, rx_data}), 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle", 32'({valid, frame_err, overrun, rx_data}), 32'h0);
        end

        // Single byte: valid appears 96 cycles after the start bit reaches rx_s.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (97) @(negedge clk);
                check("t2_pre", 32'(valid), 32'h0);
                @(negedge clk);
                check("t2_rise", 32'({valid, rx_data}), 32'h1A5);
            end
        join
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t2_hold", 32'({valid, rx_data}), 32'h1A5);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("t2_drain", 32'(valid), 32'h0);

        // Back-to-back frames with ready held high.
        repeat (10) @(negedge clk);
        acc_q.delete();
        ov0   = ov_cnt;
        ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (5) @(negedge clk);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_count", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() == 3) begin
            check("t3_b0", 32'(acc_q[0]), 32'h00);
            check("t3_b1", 32'(acc_q[1]), 32'hFF);
            check("t3_b2", 32'(acc_q[2]), 32'h3C);
        end
        check("t3_no_ovr", ov_cnt - ov0, 32'd0);

        // Overrun: second byte lost while the first is still held.
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (97) @(negedge clk);
                check("t4_pre", 32'(overrun), 32'h0);
                @(negedge clk);
                check("t4_ovr", 32'({overrun, valid, rx_data}), 32'h311);
                @(negedge clk);
                check("t4_ovr_end", 32'({overrun, valid, rx_data}), 32'h111);
            end
        join
        check("t4_ovr_cnt", ov_cnt - ov0, 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("t4_drain", 32'(valid), 32'h0);

        // Commit coincident with acceptance replaces the byte without overrun.
        ov0 = ov_cnt;
        send_frame(8'h33, 1'b1);
        fork
            send_frame(8'h44, 1'b1);
            begin
                repeat (97) @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                check("t4b_coinc", 32'({overrun, valid, rx_data}), 32'h144);
            end
        join
        check("t4b_no_ovr", ov_cnt - ov0, 32'd0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("t4b_drain", 32'(valid), 32'h0);

        // Framing error followed by a long break.
        fe0 = fe_cnt;
        fork
            send_frame(8'h55, 1'b0);
            begin
                repeat (97) @(negedge clk);
                check("t5_pre", 32'(frame_err), 32'h0);
                @(negedge clk);
                check("t5_fe", 32'({frame_err, valid}), 32'h2);
                @(negedge clk);
                check("t5_fe_end", 32'(frame_err), 32'h0);
            end
        join
        repeat (200) @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_fe_once", fe_cnt - fe0, 32'd1);
        check("t5_no_valid", 32'(valid), 32'h0);
        send_frame(8'h81, 1'b1);
        repeat (5) @(negedge clk);
        check("t5_recover", 32'({valid, rx_data}), 32'h181);

        // Short glitch is rejected; buffered byte untouched.
        fe0   = fe_cnt;
        ov0   = ov_cnt;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_glitch_fe", fe_cnt - fe0, 32'd0);
        check("t6_glitch_ov", ov_cnt - ov0, 32'd0);
        check("t6_glitch_buf", 32'({valid, rx_data}), 32'h181);

        // Reset during data bit 4 of 0xC3.
        send_bits({1'b1, 8'hC3, 1'b0}, 5);
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("t6_rst_async", 32'({valid, frame_err, overrun, rx_data}), 32'h0);
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_no_c3", 32'({valid, frame_err, overrun, rx_data}), 32'h0);
        send_frame(8'h7E, 1'b1);
        repeat (3) @(negedge clk);
        check("t6_after_rst", 32'({valid, rx_data}), 32'h17E);

        check("never_both", both_cnt, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
